store_write_buffer: RTL and testbench

//   FIFO write buffer between the processor's store path (sw) and a slow data memory.

---
 rtl/store_write_buffer.sv | 151 +++++++++++++++
 tb/tb_store_write_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// store_write_buffer: FIFO write buffer between the store path and a slow data
// memory. Stores retire in one cycle, drain over a req/ack handshake, and loads
// are forwarded from the youngest matching buffered store.
// Optional feature macro: WB_COALESCE_EN (store to the youngest entry's address
// overwrites that entry in place, unless it is the head being presented).
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  input  logic [ADDR_W-1:0]            st_addr,
  input  logic [DATA_W-1:0]            st_data,
  output logic                         st_ready,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         ld_hit,
  output logic [DATA_W-1:0]            ld_data,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ack,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t              state_r, state_next_s;
  logic [ADDR_W-1:0]   addr_r [DEPTH];
  logic [DATA_W-1:0]   data_r [DEPTH];
  logic [DEPTH-1:0]    valid_r;
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r, count_next_s;
  logic                full_s, coalesce_hit_s, alloc_s, pop_s;

  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign pop_s    = (state_r == REQ) & mem_ack;
  assign alloc_s  = st_valid & ~full_s & ~coalesce_hit_s;
  assign st_ready = ~full_s | coalesce_hit_s;

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] youngest_s;
  assign youngest_s = wr_ptr_r - PTR_W'(1);

  // Coalesce into the youngest entry unless it is the head currently presented to memory
  always_comb begin
    coalesce_hit_s = 1'b0;
    if ((count_r != CNT_W'(0)) && valid_r[youngest_s] && (addr_r[youngest_s] == st_addr) &&
        !((state_r == REQ) && (youngest_s == rd_ptr_r))) begin
      coalesce_hit_s = 1'b1;
    end else begin
      coalesce_hit_s = 1'b0;
    end
  end
`else
  assign coalesce_hit_s = 1'b0;
`endif

  // Occupancy update: push and pop in the same cycle cancel out
  always_comb begin
    count_next_s = count_r;
    case ({alloc_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Drain FSM next state: present the head while entries remain
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != CNT_W'(0)) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (pop_s) begin
          state_next_s = (count_next_s != CNT_W'(0)) ? REQ : IDLE;
        end else begin
          state_next_s = REQ;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Control registers: FSM state, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      state_r  <= state_next_s;
      count_r  <= count_next_s;
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      if (alloc_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
    end
  end

  // Entry storage: allocate at wr_ptr, invalidate the head on ack, coalesce in place
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {ADDR_W{1'b0}};
        data_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (pop_s) valid_r[rd_ptr_r] <= 1'b0;
      if (alloc_s) begin
        valid_r[wr_ptr_r] <= 1'b1;
        addr_r[wr_ptr_r]  <= st_addr;
        data_r[wr_ptr_r]  <= st_data;
      end
`ifdef WB_COALESCE_EN
      if (st_valid && coalesce_hit_s) data_r[youngest_s] <= st_data;
`endif
    end
  end

  // Load forwarding: walk oldest to youngest so the youngest match wins
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      ld_hit  = ld_hit | (valid_r[rd_ptr_r + PTR_W'(i)] &&
                          (addr_r[rd_ptr_r + PTR_W'(i)] == ld_addr));
      ld_data = (valid_r[rd_ptr_r + PTR_W'(i)] && (addr_r[rd_ptr_r + PTR_W'(i)] == ld_addr)) ?
                data_r[rd_ptr_r + PTR_W'(i)] : ld_data;
    end
  end

  // Memory side is driven only from registered state, so it holds steady until ack
  assign mem_req   = (state_r == REQ);
  assign mem_addr  = mem_req ? addr_r[rd_ptr_r] : {ADDR_W{1'b0}};
  assign mem_wdata = mem_req ? data_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed vector table followed by randomized
// traffic checked against a queue-based reference model.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
`ifdef WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, st_valid, st_ready, ld_hit, mem_req, mem_ack, empty;
  logic [31:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_wdata;
  logic [2:0]  count;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .empty(empty), .count(count)
  );

  typedef struct {
    logic rst; logic chk; logic sv; logic [31:0] sa; logic [31:0] sd; logic ack; logic [31:0] la;
    logic rdy; logic req; logic [31:0] ma; logic [31:0] md; logic [2:0] cnt; logic emp;
    logic hit; logic [31:0] ld;
  } vec_t;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  bit   mreq;

  localparam logic [31:0] NA = 32'hDEAD_0000;

  function automatic logic [102:0] pack(logic rdy, logic req, logic [31:0] ma, logic [31:0] md,
                                        logic [2:0] cnt, logic emp, logic hit, logic [31:0] ld);
    return {rdy, req, ma, md, cnt, emp, hit, ld};
  endfunction

  function automatic void add(logic rst, logic chk, logic sv, logic [31:0] sa, logic [31:0] sd,
                              logic ack, logic [31:0] la, logic rdy, logic req, logic [31:0] ma,
                              logic [31:0] md, logic [2:0] cnt, logic emp, logic hit,
                              logic [31:0] ld);
    vec_t v;
    v.rst = rst; v.chk = chk; v.sv = sv; v.sa = sa; v.sd = sd; v.ack = ack; v.la = la;
    v.rdy = rdy; v.req = req; v.ma = ma; v.md = md; v.cnt = cnt; v.emp = emp; v.hit = hit;
    v.ld = ld;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic rst, input logic sv, input logic [31:0] sa,
                       input logic [31:0] sd, input logic ack, input logic [31:0] la);
    reset = rst; st_valid = sv; st_addr = sa; st_data = sd; mem_ack = ack; ld_addr = la;
  endtask

  task automatic check(input string name, input logic [102:0] exp);
    logic [102:0] act;
    act = pack(st_ready, mem_req, mem_addr, mem_wdata, count, empty, ld_hit, ld_data);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s act=%h exp=%h (rdy,req,maddr,mdata,cnt,empty,hit,ldata)", name, act, exp);
    end
  endtask

  initial begin
    logic [102:0] exp;
    logic coal, rdy, hit, pop, sv, ack, rst;
    logic [31:0] ld, sa, sd, la, ma, md;
    int pre;

    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, NA);

    // rst chk sv addr data ack ld_addr | rdy req maddr mdata cnt empty hit ldata
    add(1,0,0,32'h0,32'h0,0,NA,        0,0,32'h0,32'h0,3'd0,0,0,32'h0);
    // single store, presentation latency, hold without ack, drain on ack
    add(0,1,1,32'h8,32'hF0F0F0F0,0,32'h8, 1,0,32'h0,32'h0,3'd0,1,0,32'h0);
    add(0,1,0,32'h0,32'h0,0,32'h8,     1,0,32'h0,32'h0,3'd1,0,1,32'hF0F0F0F0);
    add(0,1,0,32'h0,32'h0,0,32'h8,     1,1,32'h8,32'hF0F0F0F0,3'd1,0,1,32'hF0F0F0F0);
    add(0,1,0,32'h0,32'h0,1,32'h8,     1,1,32'h8,32'hF0F0F0F0,3'd1,0,1,32'hF0F0F0F0);
    add(0,1,0,32'h0,32'h0,0,32'h8,     1,0,32'h0,32'h0,3'd0,1,0,32'h0);
    // fill to full, fifth store dropped, drain in order one per cycle
    add(0,1,1,32'h0,32'hA0,0,NA,       1,0,32'h0,32'h0,3'd0,1,0,32'h0);
    add(0,1,1,32'h4,32'hA1,0,NA,       1,0,32'h0,32'h0,3'd1,0,0,32'h0);
    add(0,1,1,32'h8,32'hA2,0,NA,       1,1,32'h0,32'hA0,3'd2,0,0,32'h0);
    add(0,1,1,32'hC,32'hA3,0,NA,       1,1,32'h0,32'hA0,3'd3,0,0,32'h0);
    add(0,1,1,32'h10,32'hA4,0,32'h10,  0,1,32'h0,32'hA0,3'd4,0,0,32'h0);
    add(0,1,0,32'h0,32'h0,1,32'h0,     0,1,32'h0,32'hA0,3'd4,0,1,32'hA0);
    add(0,1,0,32'h0,32'h0,1,32'h10,    1,1,32'h4,32'hA1,3'd3,0,0,32'h0);
    add(0,1,0,32'h0,32'h0,1,32'hC,     1,1,32'h8,32'hA2,3'd2,0,1,32'hA3);
    add(0,1,0,32'h0,32'h0,1,NA,        1,1,32'hC,32'hA3,3'd1,0,0,32'h0);
    add(0,1,0,32'h0,32'h0,0,NA,        1,0,32'h0,32'h0,3'd0,1,0,32'h0);
    // same address twice: youngest forwarded, same-cycle store not forwarded
    add(0,1,1,32'hA,32'h5,0,NA,        1,0,32'h0,32'h0,3'd0,1,0,32'h0);
    add(0,1,1,32'hA,32'h7,0,32'hA,     1,0,32'h0,32'h0,3'd1,0,1,32'h5);
    add(0,1,0,32'h0,32'h0,0,32'hA,     1,1,32'hA,COAL ? 32'h7 : 32'h5,COAL ? 3'd1 : 3'd2,0,1,32'h7);
    add(0,1,0,32'h0,32'h0,0,32'h14,    1,1,32'hA,COAL ? 32'h7 : 32'h5,COAL ? 3'd1 : 3'd2,0,0,32'h0);
    // reset mid-drain
    add(1,1,0,32'h0,32'h0,0,32'hA,     1,1,32'hA,COAL ? 32'h7 : 32'h5,COAL ? 3'd1 : 3'd2,0,1,32'h7);
    add(0,1,0,32'h0,32'h0,0,32'hA,     1,0,32'h0,32'h0,3'd0,1,0,32'h0);
    // full buffer with ack and store together: store rejected, accepted next cycle
    add(0,1,1,32'h100,32'hB0,0,NA,     1,0,32'h0,32'h0,3'd0,1,0,32'h0);
    add(0,1,1,32'h104,32'hB1,0,NA,     1,0,32'h0,32'h0,3'd1,0,0,32'h0);
    add(0,1,1,32'h108,32'hB2,0,NA,     1,1,32'h100,32'hB0,3'd2,0,0,32'h0);
    add(0,1,1,32'h10C,32'hB3,0,NA,     1,1,32'h100,32'hB0,3'd3,0,0,32'h0);
    add(0,1,1,32'h110,32'hB4,0,NA,     0,1,32'h100,32'hB0,3'd4,0,0,32'h0);
    add(0,1,1,32'h110,32'hB4,1,NA,     0,1,32'h100,32'hB0,3'd4,0,0,32'h0);
    add(0,1,1,32'h110,32'hB4,0,NA,     1,1,32'h104,32'hB1,3'd3,0,0,32'h0);
    add(0,1,0,32'h0,32'h0,0,32'h110,   0,1,32'h104,32'hB1,3'd4,0,1,32'hB4);
    add(1,0,0,32'h0,32'h0,0,NA,        0,0,32'h0,32'h0,3'd0,0,0,32'h0);
    add(0,1,0,32'h0,32'h0,0,32'h110,   1,0,32'h0,32'h0,3'd0,1,0,32'h0);
`ifdef WB_COALESCE_EN
    // coalescing into a non-head youngest entry, then a new allocation
    add(0,1,1,32'h0,32'h0,0,NA,        1,0,32'h0,32'h0,3'd0,1,0,32'h0);
    add(0,1,1,32'h4,32'h1,0,NA,        1,0,32'h0,32'h0,3'd1,0,0,32'h0);
    add(0,1,1,32'h4,32'h2,0,NA,        1,1,32'h0,32'h0,3'd2,0,0,32'h0);
    add(0,1,1,32'h0,32'h9,0,32'h4,     1,1,32'h0,32'h0,3'd2,0,1,32'h2);
    add(0,1,0,32'h0,32'h0,0,32'h0,     1,1,32'h0,32'h0,3'd3,0,1,32'h9);
    add(1,0,0,32'h0,32'h0,0,NA,        0,0,32'h0,32'h0,3'd0,0,0,32'h0);
    // head being presented is never coalesced
    add(0,1,1,32'h20,32'h1,0,NA,       1,0,32'h0,32'h0,3'd0,1,0,32'h0);
    add(0,1,0,32'h0,32'h0,0,NA,        1,0,32'h0,32'h0,3'd1,0,0,32'h0);
    add(0,1,1,32'h20,32'h2,0,NA,       1,1,32'h20,32'h1,3'd1,0,0,32'h0);
    add(0,1,0,32'h0,32'h0,0,32'h20,    1,1,32'h20,32'h1,3'd2,0,1,32'h2);
`endif

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].ack, tbl[i].la);
      @(negedge clk);
      if (tbl[i].chk)
        check($sformatf("vec%0d", i), pack(tbl[i].rdy, tbl[i].req, tbl[i].ma, tbl[i].md,
                                          tbl[i].cnt, tbl[i].emp, tbl[i].hit, tbl[i].ld));
      @(posedge clk);
      #1;
    end

    // randomized traffic against a queue model
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, NA);
    @(posedge clk);
    #1;
    mq.delete();
    mreq = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      sv  = $urandom_range(0, 2) != 0;
      sa  = 32'($urandom_range(0, 7)) * 32'd4;
      sd  = $urandom;
      ack = $urandom_range(0, 2) == 0;
      la  = 32'($urandom_range(0, 8)) * 32'd4;

      coal = 1'b0;
      if (COAL && mq.size() != 0) begin
        if (mq[mq.size()-1].a == sa && !(mreq && mq.size() == 1)) coal = 1'b1;
      end
      rdy = (mq.size() != DEPTH) || coal;
      hit = 1'b0;
      ld  = 32'h0;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].a == la) begin
          hit = 1'b1;
          ld  = mq[i].d;
        end
      end
      ma = 32'h0;
      md = 32'h0;
      if (mreq) begin
        ma = mq[0].a;
        md = mq[0].d;
      end
      exp = pack(rdy, mreq, ma, md, 3'(mq.size()), mq.size() == 0, hit, ld);

      drive(rst, sv, sa, sd, ack, la);
      @(negedge clk);
      check($sformatf("rand%0d", n), exp);
      @(posedge clk);
      #1;

      if (rst) begin
        mq.delete();
        mreq = 1'b0;
      end else begin
        pre = mq.size();
        pop = mreq && ack;
        if (sv && coal) mq[mq.size()-1].d = sd;
        if (pop) void'(mq.pop_front());
        if (sv && !coal && rdy) mq.push_back('{a: sa, d: sd});
        if (!mreq) mreq = (pre != 0);
        else if (pop) mreq = (mq.size() != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
